// File: rtl/jtcus30_arb_pkg.sv
// Shared types for the CUS30 CPU-port arbiter: requester indices, FSM states
// and the round-robin successor helper.
package jtcus30_arb_pkg;

  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    REQ_MAIN = 2'd0,
    REQ_SUB  = 2'd1,
    REQ_AUD  = 2'd2
  } req_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  // Round-robin successor: main -> sub -> audio -> main
  function automatic req_e next_req(input req_e r);
    case (r)
      REQ_MAIN: next_req = REQ_SUB;
      REQ_SUB:  next_req = REQ_AUD;
      default:  next_req = REQ_MAIN;
    endcase
  endfunction

endpackage

// File: rtl/jtcus30_arb_rr.sv
// Round-robin picker: first pending requester strictly after the last owner.
module jtcus30_arb_rr
  import jtcus30_arb_pkg::*;
(
  input  logic [NREQ-1:0] pend_i,
  input  req_e            last_i,
  output req_e            grant_o,
  output logic            valid_o
);

  // Walk the ring starting after the last owner; the last owner itself comes last
  always_comb begin
    req_e c;
    c       = last_i;
    grant_o = REQ_MAIN;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      c = next_req(c);
      if (!valid_o && pend_i[c]) begin
        grant_o = c;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcus30_arb.sv
// CUS30 CPU-port arbiter: sequences main/sub/audio CPU accesses onto the single
// CUS30 bus with round-robin priority, one access per cs assertion.
// Optional macro JTCUS30_ARB_STATS_EN adds per-requester contention counters
// readable on st_dout; without it st_dout is 0 and debug_bus is ignored.
module jtcus30_arb
  import jtcus30_arb_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned ACC_CYC = 2
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          m_cs,
  input  logic          s_cs,
  input  logic          a_cs,
  input  logic          m_rnw,
  input  logic          s_rnw,
  input  logic          a_rnw,
  input  logic [AW-1:0] m_addr,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    m_dout,
  input  logic [7:0]    s_dout,
  input  logic [7:0]    a_dout,
  output logic [7:0]    m_din,
  output logic [7:0]    s_din,
  output logic [7:0]    a_din,
  output logic          m_wait,
  output logic          s_wait,
  output logic          a_wait,
  output logic          x_cs,
  output logic          x_rnw,
  output logic [AW-1:0] x_addr,
  output logic [7:0]    x_dout,
  input  logic [7:0]    x_din,
  input  logic [7:0]    debug_bus,
  output logic [7:0]    st_dout
);

  localparam int unsigned CW = $clog2(ACC_CYC);
  typedef logic [CW-1:0] cnt_t;

  logic [NREQ-1:0] cs, rnw, pend, own_oh, wait_v;
  logic [AW-1:0]   req_addr [NREQ];
  logic [7:0]      req_wdat [NREQ];

  state_e          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  req_e            owner_q, owner_d, last_q, last_d;
  logic [NREQ-1:0] served_q, served_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rnw_q, rnw_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      din_q [NREQ];
  logic [7:0]      din_d [NREQ];

  req_e            gnt;
  logic            gnt_vld;
  logic            last_cyc;

  assign cs  = {a_cs, s_cs, m_cs};
  assign rnw = {a_rnw, s_rnw, m_rnw};
  assign req_addr[0] = m_addr;
  assign req_addr[1] = s_addr;
  assign req_addr[2] = a_addr;
  assign req_wdat[0] = m_dout;
  assign req_wdat[1] = s_dout;
  assign req_wdat[2] = a_dout;

  assign pend     = cs & ~served_q;
  assign own_oh   = NREQ'(1) << owner_q;
  assign last_cyc = (cnt_q == cnt_t'(ACC_CYC - 1));

  // Wait is combinational from cs so the CPU stalls in the cycle it asks
  assign wait_v = pend & ~({NREQ{state_q == DONE}} & own_oh);
  assign m_wait = wait_v[0];
  assign s_wait = wait_v[1];
  assign a_wait = wait_v[2];

  assign m_din = din_q[0];
  assign s_din = din_q[1];
  assign a_din = din_q[2];

  // Write strobes only in the first bus cycle; later cycles are plain reads
  assign x_cs   = (state_q == ACCESS);
  assign x_rnw  = ~((state_q == ACCESS) && (cnt_q == '0) && !rnw_q);
  assign x_addr = addr_q;
  assign x_dout = dout_q;

  jtcus30_arb_rr u_rr (
    .pend_i  (pend),
    .last_i  (last_q),
    .grant_o (gnt),
    .valid_o (gnt_vld)
  );

  // Next-state: grant in IDLE, hold the bus ACC_CYC cycles, then one DONE cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    rnw_d    = rnw_q;
    dout_d   = dout_q;
    din_d    = din_q;
    served_d = served_q & cs;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = ACCESS;
          cnt_d   = '0;
          owner_d = gnt;
          addr_d  = req_addr[gnt];
          rnw_d   = rnw[gnt];
          dout_d  = req_wdat[gnt];
        end
      end
      ACCESS: begin
        if (last_cyc) begin
          state_d = DONE;
          if (rnw_q) din_d[owner_q] = x_din;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      DONE: begin
        state_d  = IDLE;
        last_d   = owner_q;
        served_d = (served_q | own_oh) & cs;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= REQ_MAIN;
      last_q   <= REQ_AUD;
      served_q <= '0;
      addr_q   <= '0;
      rnw_q    <= 1'b1;
      dout_q   <= '0;
      for (int unsigned i = 0; i < NREQ; i++) din_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      served_q <= served_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      dout_q   <= dout_d;
      din_q    <= din_d;
    end
  end

`ifdef JTCUS30_ARB_STATS_EN
  logic [7:0]      stat_q [NREQ];
  logic [NREQ-1:0] contend;
  logic            unused_dbg;

  assign contend    = wait_v & ~own_oh & {NREQ{state_q != IDLE}};
  assign unused_dbg = ^debug_bus[7:2];

  // Saturating count of cycles each requester stalls behind another owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (contend[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 8'd1;
    end
  end

  // Statistics readout select
  always_comb begin
    st_dout = '0;
    case (debug_bus[1:0])
      2'd0:    st_dout = stat_q[0];
      2'd1:    st_dout = stat_q[1];
      2'd2:    st_dout = stat_q[2];
      default: st_dout = {6'd0, last_q};
    endcase
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^debug_bus;
  assign st_dout    = '0;
`endif

endmodule

// File: tb/tb_jtcus30_arb.sv
// Directed bench for jtcus30_arb with a cycle-level transaction model and a RAM.
module tb_jtcus30_arb;

  localparam int unsigned AW  = 10;
  localparam int          ACC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_cs, s_cs, a_cs, m_rnw, s_rnw, a_rnw;
  logic [AW-1:0] m_addr, s_addr, a_addr;
  logic [7:0]    m_dout, s_dout, a_dout;
  logic [7:0]    m_din, s_din, a_din;
  logic          m_wait, s_wait, a_wait;
  logic          x_cs, x_rnw;
  logic [AW-1:0] x_addr;
  logic [7:0]    x_dout, x_din, debug_bus, st_dout;

  int checks = 0;
  int errors = 0;

  jtcus30_arb #(.AW(AW), .ACC_CYC(ACC)) dut (
    .rst(rst), .clk(clk),
    .m_cs(m_cs), .s_cs(s_cs), .a_cs(a_cs),
    .m_rnw(m_rnw), .s_rnw(s_rnw), .a_rnw(a_rnw),
    .m_addr(m_addr), .s_addr(s_addr), .a_addr(a_addr),
    .m_dout(m_dout), .s_dout(s_dout), .a_dout(a_dout),
    .m_din(m_din), .s_din(s_din), .a_din(a_din),
    .m_wait(m_wait), .s_wait(s_wait), .a_wait(a_wait),
    .x_cs(x_cs), .x_rnw(x_rnw), .x_addr(x_addr), .x_dout(x_dout), .x_din(x_din),
    .debug_bus(debug_bus), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  // CUS30 RAM: one-cycle read latency
  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (x_cs && !x_rnw) ram[x_addr] <= x_dout;
    x_din <= ram[x_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] req_addr(input int r);
    case (r)
      0: return m_addr;
      1: return s_addr;
      default: return a_addr;
    endcase
  endfunction

  function automatic logic [7:0] req_dout(input int r);
    case (r)
      0: return m_dout;
      1: return s_dout;
      default: return a_dout;
    endcase
  endfunction

  // Model: an access granted in cycle g owns cycles g+1..g+ACC (bus) and g+ACC+1 (done);
  // the arbiter may grant again from cycle g+ACC+2.
  int         t = 0;
  bit         busy = 1'b0;
  int         g = 0;
  int         own = 0;
  int         last = 2;
  bit         mrnw;
  logic [AW-1:0] maddr;
  logic [7:0] mdout;
  bit [2:0]   served = '0;
  logic [7:0] din_exp [3];
  logic [7:0] ram_ref [1024];
  int         strobes = 0;
  int         xcs_cnt = 0;
  logic [AW-1:0] mon_addr = '0;

  always @(negedge clk) begin
    bit [2:0] cs, rnw_v, pend, ew;
    bit in_acc, in_done, idle;
    int r;
    t++;
    cs    = {a_cs, s_cs, m_cs};
    rnw_v = {a_rnw, s_rnw, m_rnw};
    if (rst) begin
      busy = 1'b0; served = '0; last = 2;
      for (int i = 0; i < 3; i++) din_exp[i] = 8'h00;
    end
    in_acc  = busy && (t > g) && (t <= g + ACC);
    in_done = busy && (t == g + ACC + 1);
    idle    = !busy || (t >= g + ACC + 2);
    for (int i = 0; i < 3; i++)
      ew[i] = cs[i] && !served[i] && !(in_done && own == i);
    chk("m_wait", m_wait, ew[0]);
    chk("s_wait", s_wait, ew[1]);
    chk("a_wait", a_wait, ew[2]);
    chk("x_cs", x_cs, in_acc);
    chk("x_rnw", x_rnw, !(in_acc && t == g + 1 && !mrnw));
    if (in_acc) begin
      chk("x_addr", x_addr, maddr);
      chk("x_dout", x_dout, mdout);
    end
    chk("m_din", m_din, din_exp[0]);
    chk("s_din", s_din, din_exp[1]);
    chk("a_din", a_din, din_exp[2]);
`ifndef JTCUS30_ARB_STATS_EN
    chk("st_dout", st_dout, 0);
`endif
    if (x_cs && !x_rnw && x_addr == mon_addr) strobes++;
    if (x_cs) xcs_cnt++;
    if (!rst) begin
      if (in_acc && t == g + 1 && !mrnw) ram_ref[maddr] = mdout;
      if (in_acc && t == g + ACC && mrnw) din_exp[own] = ram_ref[maddr];
      pend = cs & ~served;
      for (int i = 0; i < 3; i++)
        served[i] = cs[i] && (served[i] || (in_done && own == i));
      if (in_done) last = own;
      if (idle) begin
        busy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          r = (last + k) % 3;
          if (pend[r] && !busy) begin
            busy = 1'b1; g = t; own = r;
            mrnw = rnw_v[r]; maddr = req_addr(r); mdout = req_dout(r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count sampled cycles with requester r's wait high until it falls
  task automatic wait_fall(input int r, output int hi);
    logic [2:0] w;
    hi = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      w = {a_wait, s_wait, m_wait};
      if (!w[r]) return;
      hi++;
    end
    checks++; errors++;
    $display("FAIL wait_timeout: requester %0d still waiting after 50 cycles", r);
  endtask

  // Three-way contention: returns fall order encoded base-4 and audio stall length
  task automatic triple(output int code, output int ahi);
    logic [2:0] w;
    bit [2:0] seen;
    code = 0; ahi = 0; seen = '0;
    for (int k = 0; k < 60 && seen != 3'b111; k++) begin
      @(negedge clk);
      w = {a_wait, s_wait, m_wait};
      if (w[2]) ahi++;
      for (int i = 0; i < 3; i++)
        if (!seen[i] && !w[i]) begin
          seen[i] = 1'b1;
          code = code * 4 + i;
        end
    end
    if (seen != 3'b111) begin
      checks++; errors++;
      $display("FAIL triple_timeout: seen=%b expected 111", seen);
    end
  endtask

  initial begin
    int hi, code;
    m_cs = 0; s_cs = 0; a_cs = 0; m_rnw = 1; s_rnw = 1; a_rnw = 1;
    m_addr = '0; s_addr = '0; a_addr = '0; m_dout = '0; s_dout = '0; a_dout = '0;
    debug_bus = '0;
    repeat (2) @(negedge clk);
    chk("rst_x_cs", x_cs, 0);
    chk("rst_x_rnw", x_rnw, 1);
    chk("rst_x_addr", x_addr, 0);
    chk("rst_x_dout", x_dout, 0);
    chk("rst_a_din", a_din, 0);
    tick(); rst = 0; repeat (3) tick();

    // Single write, then cs held: exactly one access
    mon_addr = 10'h123; strobes = 0; xcs_cnt = 0;
    m_cs = 1; m_rnw = 0; m_addr = 10'h123; m_dout = 8'h5A;
    wait_fall(0, hi);
    chk("wr_wait_cycles", hi, 3);
    repeat (6) tick();
    chk("hold_xcs_cycles", xcs_cnt, ACC);
    chk("wr_strobes", strobes, 1);
    chk("ram_123", ram[10'h123], 8'h5A);
    chk("wr_keeps_m_din", m_din, 8'h00);
    m_cs = 0; tick();
    m_cs = 1; m_rnw = 1;
    wait_fall(0, hi);
    chk("reread_m_din", m_din, 8'h5A);
    tick(); m_cs = 0; tick();
    chk("reissue_xcs_cycles", xcs_cnt, 2 * ACC);

    // Audio preloads 0x040, sub reads it back
    a_cs = 1; a_rnw = 0; a_addr = 10'h040; a_dout = 8'h3C;
    wait_fall(2, hi);
    tick(); a_cs = 0; tick();
    s_cs = 1; s_rnw = 1; s_addr = 10'h040;
    wait_fall(1, hi);
    chk("rd_s_din", s_din, 8'h3C);
    chk("rd_m_din_kept", m_din, 8'h5A);
    chk("rd_a_din_kept", a_din, 8'h00);
    tick(); s_cs = 0; tick();

    // Audio (next in ring) drops cs mid-write; main then gets the bus
    mon_addr = 10'h0AA; strobes = 0;
    a_cs = 1; a_rnw = 0; a_addr = 10'h0AA; a_dout = 8'h77;
    m_cs = 1; m_rnw = 1; m_addr = 10'h040;
    tick(); tick();
    a_cs = 0;
    wait_fall(0, hi);
    chk("drop_main_wait", hi, 5);
    chk("drop_m_din", m_din, 8'h3C);
    chk("drop_strobes", strobes, 1);
    chk("ram_0aa", ram[10'h0AA], 8'h77);
    tick(); m_cs = 0; tick();

    // Reset, then two rounds of three simultaneous reads
    rst = 1;
    @(negedge clk);
    chk("rst2_m_din", m_din, 8'h00);
    chk("rst2_s_din", s_din, 8'h00);
    tick(); rst = 0; tick();
    m_addr = 10'h123; s_addr = 10'h040; a_addr = 10'h0AA;
    m_rnw = 1; s_rnw = 1; a_rnw = 1;
    m_cs = 1; s_cs = 1; a_cs = 1;
    triple(code, hi);
    chk("rr_order1", code, 6);
    chk("rr_aud_wait1", hi, 3 * (ACC + 2) - 1);
    chk("rr1_m_din", m_din, 8'h5A);
    chk("rr1_s_din", s_din, 8'h3C);
    chk("rr1_a_din", a_din, 8'h77);
    tick(); m_cs = 0; s_cs = 0; a_cs = 0; tick();
    m_addr = 10'h0AA; s_addr = 10'h123; a_addr = 10'h040;
    m_cs = 1; s_cs = 1; a_cs = 1;
    triple(code, hi);
    chk("rr_order2", code, 6);
    chk("rr_aud_wait2", hi, 11);
    chk("rr2_m_din", m_din, 8'h77);
    chk("rr2_s_din", s_din, 8'h5A);
    chk("rr2_a_din", a_din, 8'h3C);
    tick(); m_cs = 0; s_cs = 0; a_cs = 0; tick();

    // Reset while the bus is mid-write
    m_cs = 1; m_rnw = 0; m_addr = 10'h200; m_dout = 8'hEE;
    tick(); tick();
    rst = 1;
    @(negedge clk);
    chk("rst_acc_x_cs", x_cs, 0);
    chk("rst_acc_m_wait", m_wait, 1);
    chk("rst_acc_m_din", m_din, 8'h00);
    chk("rst_acc_a_din", a_din, 8'h00);
    tick(); tick();
    rst = 0; m_cs = 0;
    @(negedge clk);
    chk("post_rst_m_wait", m_wait, 0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
